mem_req_initiator: RTL and testbench
====================================

// Module: mem_req_initiator
// PURPOSE
//  Bus initiator for the word-addressed req/ready memory interface used by the xbar controller ports.
//  - Accepts read/write commands on a valid/ready stream and buffers them in a FIFO.
//  - Issues each command as one held req_o transaction; returns rdata plus measured latency on a response stream.
//  - Sits in front of an xbar controller port: DMA/debug-style masters, and the bench traffic source.
// PARAMETERS
//  WORD_ADDR_WIDTH  16  word address width of the bus (matches xbar controller ports)
//  FIFO_DEPTH       4   command FIFO entries; power of two, >=2
//  LAT_W            8   width of latency counter; saturates at 2**LAT_W-1
// PORTS
//  clk_i        in   1                single clock
//  rst_i        in   1                reset, synchronous, active-high
//  cmd_valid_i  in   1                command offered
//  cmd_ready_o  out  1                FIFO can accept (count < FIFO_DEPTH)
//  cmd_wen_i    in   1                1=write, 0=read
//  cmd_addr_i   in   WORD_ADDR_WIDTH  word address
//  cmd_wdata_i  in   32               write data
//  cmd_be_i     in   4                byte enables (forwarded unchanged, also on reads)
//  rsp_valid_o  out  1                response available
//  rsp_ready_i  in   1                response consumer ready
//  rsp_wen_o    out  1                echo of command wen
//  rsp_rdata_o  out  32               read data; 0 for writes
//  rsp_lat_o    out  LAT_W            req_o-high cycles incl. ready cycle
//  req_o        out  1                bus request
//  addr_o       out  WORD_ADDR_WIDTH  bus address
//  wen_o        out  1                bus write enable
//  wdata_o      out  32               bus write data
//  be_o         out  4                bus byte enables
//  rdata_i      in   32               bus read data, valid in the ready_i cycle
//  ready_i      in   1                bus completion strobe
//  busy_o       out  1                FIFO non-empty or FSM not IDLE
// BEHAVIOUR
//  Reset: synchronous, active-high.
//  - All outputs, including cmd_ready_o, are 0 while rst_i is high; FIFO is emptied; FSM goes to IDLE; latency counter is 0.
//  - cmd_ready_o is 1 in the first cycle after rst_i falls.
//  - Reset mid-transaction: req_o is low in the cycle after the reset edge; any later ready_i is ignored; the pending response is dropped.
//  Command FIFO:
//  - Push on cmd_valid_i & cmd_ready_o.
//  - cmd_ready_o is derived from the registered count only, so there is no push while full even if a pop occurs in the same cycle.
//  - Not fall-through: an entry pushed into an empty FIFO is visible to the FSM in the next cycle.
//  - Pointers wrap modulo FIFO_DEPTH; an extra count bit distinguishes full from empty.
//  FSM, all bus outputs registered:
//  - IDLE: if FIFO non-empty, pop the head, load addr/wen/wdata/be registers, set req_o, latency counter <= 1, go to BUS.
//  - BUS: req_o and all bus fields held stable.
//      - ready_i=0: counter increments, saturating.
//      - ready_i=1: capture rdata_i (or 0 if write), wen, and counter; clear req_o; go to RSP.
//  - RSP: rsp_valid_o=1 with fields stable; on rsp_ready_i go to IDLE.
//  - req_o is low for at least 2 cycles between transactions (the RSP and IDLE cycles).
//  - Minimum command-to-req latency is 2 cycles: push, then the IDLE pop cycle, with req_o high in the cycle after.
//  - ready_i outside BUS is ignored; rdata_i is sampled only in BUS & ready_i.
//  - One transaction is outstanding at a time; responses are returned in command order; no response is ever dropped except by reset.
//  - Responder answering in the first req cycle gives rsp_lat_o=1.
//  - Counter overflow: rsp_lat_o = 2**LAT_W-1, no wrap.
// STRUCTURE
//  Package mem_init_pkg:
//  - cmd_t struct {wen, addr, wdata, be}, parameterised via WORD_ADDR_WIDTH localparam in the instantiating module.
//  - rsp_t struct {wen, rdata, lat}.
//  - state_e enum {IDLE, BUS, RSP}.
//  Sub-module mem_init_fifo: synchronous FIFO of cmd_t, with push/pop/full/empty/count.
//  Top holds the FSM, bus registers, latency counter and response register.
// TESTING (bench: mem_req_initiator -> mock_memory, programmable delay)
//  1. Write then read: write addr 0x10, data 0xDEADBEEF, be 0xF; then read 0x10.
//     -> rsp1 wen=1, rdata=0; rsp2 wen=0, rdata=0xDEADBEEF.
//  2. Latency: responder asserts ready in the 1st, then 4th req cycle. -> rsp_lat_o 1, then 4.
//     Then ready withheld for 300 cycles with LAT_W=8. -> rsp_lat_o=255.
//  3. Full FIFO: rsp_ready_i=0, push 6 commands back-to-back.
//     -> 5 accepted (4 in FIFO + 1 popped into BUS); cmd_ready_o=0 until the first response is consumed.
//  4. Back-pressure: rsp_ready_i held low for 10 cycles.
//     -> rsp_valid_o and fields stable throughout; req_o stays low; no second bus request issued.
//  5. Byte enables: write be=0x3, data 0x11223344 over 0xFFFFFFFF, then read.
//     -> be_o=0x3 held during BUS; readback 0xFFFF3344.
//  6. Reset in BUS: assert rst_i while req_o=1 and the responder is mid-delay.
//     -> req_o=0 next cycle; late ready_i ignored; rsp_valid_o never asserts; busy_o=0.
//     Then a fresh read completes normally.

Source files
------------

// File: rtl/mem_init_pkg.sv
// Shared types for the word-addressed req/ready bus initiator: command and
// response records plus the transaction FSM state encoding.
package mem_init_pkg;

   // Default widths; the top-level WORD_ADDR_WIDTH and LAT_W must keep these values.
   localparam int CMD_ADDR_W = 16;
   localparam int RSP_LAT_W  = 8;

   typedef struct packed {
      logic                  wen;
      logic [CMD_ADDR_W-1:0] addr;
      logic [31:0]           wdata;
      logic [3:0]            be;
   } cmd_t;

   typedef struct packed {
      logic                 wen;
      logic [31:0]          rdata;
      logic [RSP_LAT_W-1:0] lat;
   } rsp_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RSP  = 2'd2
   } state_e;

endpackage

// File: rtl/mem_init_fifo.sv
// Synchronous command FIFO. Not fall-through: a pushed entry becomes visible
// to the consumer one cycle later, when the registered count updates.
module mem_init_fifo
   import mem_init_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  cmd_t                       data_i,
   input  logic                       pop_i,
   output cmd_t                       data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   cmd_t             mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; the count guards every read, so stale entries are never used.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/mem_req_initiator.sv
// Bus initiator: buffers commands, issues each as one held req_o transaction,
// and returns read data plus the measured req_o-high latency.
module mem_req_initiator
   import mem_init_pkg::*;
#(
   parameter int WORD_ADDR_WIDTH = CMD_ADDR_W,
   parameter int FIFO_DEPTH      = 4,
   parameter int LAT_W           = RSP_LAT_W
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       cmd_valid_i,
   output logic                       cmd_ready_o,
   input  logic                       cmd_wen_i,
   input  logic [WORD_ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [31:0]                cmd_wdata_i,
   input  logic [3:0]                 cmd_be_i,
   output logic                       rsp_valid_o,
   input  logic                       rsp_ready_i,
   output logic                       rsp_wen_o,
   output logic [31:0]                rsp_rdata_o,
   output logic [LAT_W-1:0]           rsp_lat_o,
   output logic                       req_o,
   output logic [WORD_ADDR_WIDTH-1:0] addr_o,
   output logic                       wen_o,
   output logic [31:0]                wdata_o,
   output logic [3:0]                 be_o,
   input  logic [31:0]                rdata_i,
   input  logic                       ready_i,
   output logic                       busy_o
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   cmd_t             fifo_wdata, fifo_rdata;
   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CNT_W-1:0] fifo_count;

   state_e           state_q, state_d;
   logic             req_q, req_d;
   cmd_t             bus_q, bus_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   rsp_t             rsp_q, rsp_d;
   logic             rsp_valid_q, rsp_valid_d;

   // Ready depends only on registered state, so a same-cycle pop never frees a slot.
   assign cmd_ready_o = ~rst_i & ~fifo_full;
   assign fifo_push   = cmd_valid_i & cmd_ready_o;
   assign fifo_wdata  = '{wen: cmd_wen_i, addr: cmd_addr_i, wdata: cmd_wdata_i, be: cmd_be_i};

   mem_init_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .data_i  (fifo_wdata),
      .pop_i   (fifo_pop),
      .data_o  (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      bus_d       = bus_q;
      lat_d       = lat_q;
      rsp_d       = rsp_q;
      rsp_valid_d = rsp_valid_q;
      fifo_pop    = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               bus_d    = fifo_rdata;
               req_d    = 1'b1;
               lat_d    = LAT_W'(1);
               state_d  = BUS;
            end
         end
         BUS: begin
            if (ready_i) begin
               rsp_d.wen   = bus_q.wen;
               rsp_d.rdata = bus_q.wen ? 32'h0 : rdata_i;
               rsp_d.lat   = lat_q;
               rsp_valid_d = 1'b1;
               req_d       = 1'b0;
               state_d     = RSP;
            end else if (lat_q != '1) begin
               lat_d = lat_q + 1'b1;
            end
         end
         RSP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         req_q       <= 1'b0;
         bus_q       <= '0;
         lat_q       <= '0;
         rsp_q       <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         bus_q       <= bus_d;
         lat_q       <= lat_d;
         rsp_q       <= rsp_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign req_o       = req_q;
   assign addr_o      = bus_q.addr;
   assign wen_o       = bus_q.wen;
   assign wdata_o     = bus_q.wdata;
   assign be_o        = bus_q.be;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_wen_o   = rsp_q.wen;
   assign rsp_rdata_o = rsp_q.rdata;
   assign rsp_lat_o   = rsp_q.lat;
   assign busy_o      = ~rst_i & ((fifo_count != '0) | (state_q != IDLE));

endmodule

// File: tb/tb_mem_req_initiator.sv
// Directed bench: mem_req_initiator driving a mock memory with programmable ready delay.
module tb_mem_req_initiator;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic        cmd_wen_i = 1'b0;
   logic [15:0] cmd_addr_i = '0;
   logic [31:0] cmd_wdata_i = '0;
   logic [3:0]  cmd_be_i = '0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic        rsp_wen_o;
   logic [31:0] rsp_rdata_o;
   logic [7:0]  rsp_lat_o;
   logic        req_o;
   logic [15:0] addr_o;
   logic        wen_o;
   logic [31:0] wdata_o;
   logic [3:0]  be_o;
   logic [31:0] rdata_i;
   logic        ready_i;
   logic        busy_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_req_initiator #(
      .WORD_ADDR_WIDTH (16),
      .FIFO_DEPTH      (4),
      .LAT_W           (8)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_wen_i   (cmd_wen_i),
      .cmd_addr_i  (cmd_addr_i),
      .cmd_wdata_i (cmd_wdata_i),
      .cmd_be_i    (cmd_be_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_wen_o   (rsp_wen_o),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_lat_o   (rsp_lat_o),
      .req_o       (req_o),
      .addr_o      (addr_o),
      .wen_o       (wen_o),
      .wdata_o     (wdata_o),
      .be_o        (be_o),
      .rdata_i     (rdata_i),
      .ready_i     (ready_i),
      .busy_o      (busy_o)
   );

   // Mock memory: contents stored XOR a per-address pattern so unwritten words read as pat(addr).
   int          delay = 1;
   int          req_cnt = 0;
   logic        stray_ready = 1'b0;
   logic [31:0] mem [256] = '{default: 32'h0};

   function automatic logic [31:0] pat(input logic [7:0] a);
      return 32'hA500_0000 | {24'h0, a};
   endfunction

   function automatic logic [31:0] be_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] be);
      logic [31:0] m;
      m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (old_w & ~m) | (new_w & m);
   endfunction

   assign rdata_i = mem[addr_o[7:0]] ^ pat(addr_o[7:0]);
   assign ready_i = (req_o && (req_cnt == delay - 1)) || stray_ready;

   always @(posedge clk) begin
      req_cnt <= (req_o && !ready_i) ? req_cnt + 1 : 0;
      if (req_o && ready_i && wen_o)
         mem[addr_o[7:0]] <= be_merge(rdata_i, wdata_o, be_o) ^ pat(addr_o[7:0]);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic wen, input logic [15:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be);
      bit done = 0;
      cmd_valid_i = 1'b1;
      cmd_wen_i   = wen;
      cmd_addr_i  = addr;
      cmd_wdata_i = wdata;
      cmd_be_i    = be;
      for (int i = 0; i < 200 && !done; i++) begin
         if (cmd_ready_o) done = 1;
         tick();
      end
      cmd_valid_i = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL send_cmd_timeout addr=%h: cmd_ready_o never 1", addr);
      end
   endtask

   task automatic get_rsp(output logic wen, output logic [31:0] rdata, output logic [7:0] lat);
      bit seen = 0;
      wen   = 1'bx;
      rdata = 'x;
      lat   = 'x;
      rsp_ready_i = 1'b1;
      for (int i = 0; i < 400 && !seen; i++) begin
         if (rsp_valid_o) begin
            seen  = 1;
            wen   = rsp_wen_o;
            rdata = rsp_rdata_o;
            lat   = rsp_lat_o;
         end
         tick();
      end
      rsp_ready_i = 1'b0;
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL get_rsp_timeout: rsp_valid_o never 1");
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) tick();
      checks++;
      if ({cmd_ready_o, req_o, rsp_valid_o, busy_o} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs: got ready/req/rsp_valid/busy=%b want 0000",
                  {cmd_ready_o, req_o, rsp_valid_o, busy_o});
      end
      rst_i = 1'b0;
      #1;
      checks++;
      if (cmd_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b want 1", cmd_ready_o);
      end
      tick();
   endtask

   task automatic test_write_read();
      logic w; logic [31:0] d; logic [7:0] l;
      delay = 1;
      send_cmd(1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF);
      checks++;
      if (req_o !== 1'b0) begin
         errors++;
         $display("FAIL min_latency_pop_cycle: req_o=%b want 0", req_o);
      end
      tick();
      checks++;
      if ({req_o, addr_o, wen_o, wdata_o, be_o} !== {1'b1, 16'h0010, 1'b1, 32'hDEAD_BEEF, 4'hF}) begin
         errors++;
         $display("FAIL bus_fields_write: req=%b addr=%h wen=%b wdata=%h be=%h want 1 0010 1 deadbeef f",
                  req_o, addr_o, wen_o, wdata_o, be_o);
      end
      get_rsp(w, d, l);
      checks++;
      if ({w, d, l} !== {1'b1, 32'h0, 8'd1}) begin
         errors++;
         $display("FAIL write_rsp: wen=%b rdata=%h lat=%0d want 1 00000000 1", w, d, l);
      end
      send_cmd(1'b0, 16'h0010, 32'h0, 4'hF);
      get_rsp(w, d, l);
      checks++;
      if ({w, d} !== {1'b0, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL read_rsp: wen=%b rdata=%h want 0 deadbeef", w, d);
      end
   endtask

   task automatic test_latency();
      logic w; logic [31:0] d; logic [7:0] l;
      int          dly [3] = '{1, 4, 301};
      logic [7:0]  exp [3] = '{8'd1, 8'd4, 8'd255};
      for (int k = 0; k < 3; k++) begin
         delay = dly[k];
         send_cmd(1'b0, 16'h0011, 32'h0, 4'hF);
         get_rsp(w, d, l);
         checks++;
         if ({l, d} !== {exp[k], pat(8'h11)}) begin
            errors++;
            $display("FAIL latency_delay%0d: lat=%0d rdata=%h want %0d %h", dly[k], l, d, exp[k], pat(8'h11));
         end
      end
      delay = 1;
   endtask

   task automatic test_full_fifo();
      logic w; logic [31:0] d; logic [7:0] l;
      int acc = 0;
      delay = 1;
      rsp_ready_i = 1'b0;
      cmd_valid_i = 1'b1;
      cmd_wen_i   = 1'b0;
      cmd_be_i    = 4'hF;
      for (int i = 0; i < 6; i++) begin
         cmd_addr_i = 16'h0020 + 16'(i);
         if (cmd_ready_o) acc++;
         tick();
      end
      cmd_valid_i = 1'b0;
      checks++;
      if (acc != 5) begin
         errors++;
         $display("FAIL full_accept_count: accepted=%0d want 5", acc);
      end
      repeat (5) tick();
      checks++;
      if ({cmd_ready_o, rsp_valid_o, req_o} !== 3'b010) begin
         errors++;
         $display("FAIL full_hold: ready/rsp_valid/req=%b want 010", {cmd_ready_o, rsp_valid_o, req_o});
      end
      get_rsp(w, d, l);
      checks++;
      if (d !== pat(8'h20)) begin
         errors++;
         $display("FAIL full_rsp0: rdata=%h want %h", d, pat(8'h20));
      end
      tick();
      checks++;
      if (cmd_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL full_ready_after_consume: got %b want 1", cmd_ready_o);
      end
      for (int k = 1; k < 5; k++) begin
         get_rsp(w, d, l);
         checks++;
         if (d !== pat(8'(8'h20 + k))) begin
            errors++;
            $display("FAIL full_rsp%0d: rdata=%h want %h", k, d, pat(8'(8'h20 + k)));
         end
      end
      repeat (4) tick();
      checks++;
      if ({busy_o, rsp_valid_o, req_o} !== 3'b000) begin
         errors++;
         $display("FAIL full_drained: busy/rsp_valid/req=%b want 000", {busy_o, rsp_valid_o, req_o});
      end
   endtask

   task automatic test_back_pressure();
      logic w; logic [31:0] d; logic [7:0] l;
      bit seen = 0;
      delay = 2;
      rsp_ready_i = 1'b0;
      send_cmd(1'b0, 16'h0050, 32'h0, 4'hF);
      send_cmd(1'b0, 16'h0051, 32'h0, 4'hF);
      for (int i = 0; i < 50 && !seen; i++) begin
         if (rsp_valid_o) seen = 1;
         else tick();
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL bp_first_rsp_timeout: rsp_valid_o never 1");
      end
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++;
         if ({rsp_valid_o, rsp_wen_o, rsp_rdata_o, rsp_lat_o, req_o} !==
             {1'b1, 1'b0, pat(8'h50), 8'd2, 1'b0}) begin
            errors++;
            $display("FAIL bp_stable_c%0d: valid=%b wen=%b rdata=%h lat=%0d req=%b want 1 0 %h 2 0",
                     c, rsp_valid_o, rsp_wen_o, rsp_rdata_o, rsp_lat_o, req_o, pat(8'h50));
         end
      end
      get_rsp(w, d, l);
      get_rsp(w, d, l);
      checks++;
      if ({d, l} !== {pat(8'h51), 8'd2}) begin
         errors++;
         $display("FAIL bp_second_rsp: rdata=%h lat=%0d want %h 2", d, l, pat(8'h51));
      end
      delay = 1;
   endtask

   task automatic test_byte_enables();
      logic w; logic [31:0] d; logic [7:0] l;
      delay = 1;
      send_cmd(1'b1, 16'h0030, 32'hFFFF_FFFF, 4'hF);
      get_rsp(w, d, l);
      delay = 3;
      send_cmd(1'b1, 16'h0030, 32'h1122_3344, 4'h3);
      tick();
      for (int c = 0; c < 3; c++) begin
         checks++;
         if ({req_o, be_o, addr_o, wdata_o} !== {1'b1, 4'h3, 16'h0030, 32'h1122_3344}) begin
            errors++;
            $display("FAIL be_held_c%0d: req=%b be=%h addr=%h wdata=%h want 1 3 0030 11223344",
                     c, req_o, be_o, addr_o, wdata_o);
         end
         tick();
      end
      get_rsp(w, d, l);
      checks++;
      if ({w, l} !== {1'b1, 8'd3}) begin
         errors++;
         $display("FAIL be_write_rsp: wen=%b lat=%0d want 1 3", w, l);
      end
      delay = 1;
      send_cmd(1'b0, 16'h0030, 32'h0, 4'hF);
      get_rsp(w, d, l);
      checks++;
      if (d !== 32'hFFFF_3344) begin
         errors++;
         $display("FAIL be_readback: rdata=%h want ffff3344", d);
      end
   endtask

   task automatic test_reset_in_bus();
      logic w; logic [31:0] d; logic [7:0] l;
      bit rsp_seen = 0;
      delay = 20;
      send_cmd(1'b0, 16'h0040, 32'h0, 4'hF);
      repeat (4) tick();
      checks++;
      if (req_o !== 1'b1) begin
         errors++;
         $display("FAIL rst_bus_precondition: req_o=%b want 1", req_o);
      end
      rst_i = 1'b1;
      tick();
      checks++;
      if ({req_o, rsp_valid_o, busy_o, cmd_ready_o} !== 4'b0000) begin
         errors++;
         $display("FAIL rst_bus_outputs: req/rsp_valid/busy/ready=%b want 0000",
                  {req_o, rsp_valid_o, busy_o, cmd_ready_o});
      end
      rst_i = 1'b0;
      stray_ready = 1'b1;
      repeat (2) tick();
      stray_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (rsp_valid_o || req_o) rsp_seen = 1;
         tick();
      end
      checks++;
      if ({rsp_seen, busy_o} !== 2'b00) begin
         errors++;
         $display("FAIL rst_bus_quiet: activity=%b busy=%b want 0 0", rsp_seen, busy_o);
      end
      delay = 2;
      send_cmd(1'b0, 16'h0040, 32'h0, 4'hF);
      get_rsp(w, d, l);
      checks++;
      if ({w, d, l} !== {1'b0, pat(8'h40), 8'd2}) begin
         errors++;
         $display("FAIL rst_bus_fresh_read: wen=%b rdata=%h lat=%0d want 0 %h 2", w, d, l, pat(8'h40));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_read();
      test_latency();
      test_full_fifo();
      test_back_pressure();
      test_byte_enables();
      test_reset_in_bus();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
